// File: rtl/student_audio_stream_bridge.sv
// student_audio_stream_bridge
// Buffers the IIS handler's per-frame stereo ADC sample into a ready/valid
// stream for the FIR filter array. It also catches filtered results in a
// one-entry hold register and hands them to the DAC side on each frame tick.
// Dropped ADC samples and missed DAC updates are counted for debug.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   adc_l_i, adc_r_i, adc_valid_i ADC sample and level-type frame valid
//   bypass_i                      1 = DAC fed straight from ADC samples
//   clear_cnt_i                   synchronous clear of both debug counters
//   m_valid_o, m_ready_i,
//   m_l_o, m_r_o                  first-word-fall-through stream to filter
//   s_valid_i, s_ready_o,
//   s_l_i, s_r_i                  filtered result stream from filter
//   dac_l_o, dac_r_o              registered DAC samples to IIS handler
//   overflow_cnt_o                saturating count of dropped ADC samples
//   underrun_cnt_o                saturating count of ticks with no result
module student_audio_stream_bridge #(
  parameter int DW    = 16,
  parameter int DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [DW-1:0] adc_l_i,
  input  logic [DW-1:0] adc_r_i,
  input  logic          adc_valid_i,
  input  logic          bypass_i,
  input  logic          clear_cnt_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic [DW-1:0] m_l_o,
  output logic [DW-1:0] m_r_o,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic [DW-1:0] s_l_i,
  input  logic [DW-1:0] s_r_i,
  output logic [DW-1:0] dac_l_o,
  output logic [DW-1:0] dac_r_o,
  output logic [7:0]    overflow_cnt_o,
  output logic [7:0]    underrun_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Saturating 8-bit debug counter; a clear wins over an increment.
  function automatic logic [7:0] sat_cnt(input logic [7:0] cnt, input logic inc, input logic clr);
    logic [7:0] res;
    if (clr) begin
      res = 8'd0;
    end else if (inc && (cnt != 8'd255)) begin
      res = cnt + 8'd1;
    end else begin
      res = cnt;
    end
    return res;
  endfunction

  logic [2*DW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            adc_valid_q;
  logic            tick;
  logic            fifo_full;
  logic            push_req;
  logic            push;
  logic            pop;
  logic            overflow;

  logic            hold_full;
  logic [DW-1:0]   hold_l;
  logic [DW-1:0]   hold_r;
  logic            s_hs;

  logic            hold_full_n;
  logic [DW-1:0]   hold_l_n;
  logic [DW-1:0]   hold_r_n;
  logic [DW-1:0]   dac_l_n;
  logic [DW-1:0]   dac_r_n;
  logic            underrun;

  // One tick per rising edge of the level-type ADC valid.
  assign tick      = adc_valid_i & ~adc_valid_q;
  assign fifo_full = (count == DEPTH_C);
  assign m_valid_o = (count != {CW{1'b0}});
  assign pop       = m_valid_o & m_ready_i;
  assign push_req  = tick & ~bypass_i;
  // A full FIFO still accepts a push when a pop frees the head slot that cycle.
  assign push      = push_req & (~fifo_full | pop);
  assign overflow  = push_req & fifo_full & ~pop;
  assign {m_l_o, m_r_o} = mem[rd_ptr];

  assign s_ready_o = ~hold_full;
  assign s_hs      = s_valid_i & ~hold_full;

  // Edge-detect register for the ADC valid level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      adc_valid_q <= 1'b0;
    end else begin
      adc_valid_q <= adc_valid_i;
    end
  end

  // FIFO storage, pointers and occupancy; pointers wrap as DEPTH is a power of 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {(2*DW){1'b0}};
      end
      wr_ptr <= {AW{1'b0}};
      rd_ptr <= {AW{1'b0}};
      count  <= {CW{1'b0}};
    end else begin
      if (push) begin
        mem[wr_ptr] <= {adc_l_i, adc_r_i};
        wr_ptr      <= wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push, pop})
        2'b10:   count <= count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count <= count - {{(CW-1){1'b0}}, 1'b1};
        default: count <= count;
      endcase
    end
  end

  // Next-state for the hold register and DAC, resolved on the frame tick.
  always_comb begin
    hold_full_n = hold_full;
    hold_l_n    = hold_l;
    hold_r_n    = hold_r;
    dac_l_n     = dac_l_o;
    dac_r_n     = dac_r_o;
    underrun    = 1'b0;
    if (tick) begin
      if (bypass_i) begin
        dac_l_n     = adc_l_i;
        dac_r_n     = adc_r_i;
        hold_full_n = 1'b0;
      end else if (hold_full) begin
        dac_l_n     = hold_l;
        dac_r_n     = hold_r;
        hold_full_n = 1'b0;
      end else if (s_hs) begin
        // Result arriving exactly on the tick goes straight through.
        dac_l_n = s_l_i;
        dac_r_n = s_r_i;
      end else begin
        underrun = 1'b1;
      end
    end else if (s_hs) begin
      hold_l_n    = s_l_i;
      hold_r_n    = s_r_i;
      hold_full_n = 1'b1;
    end else begin
      hold_full_n = hold_full;
    end
  end

  // Hold register, DAC outputs and debug counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_full      <= 1'b0;
      hold_l         <= {DW{1'b0}};
      hold_r         <= {DW{1'b0}};
      dac_l_o        <= {DW{1'b0}};
      dac_r_o        <= {DW{1'b0}};
      overflow_cnt_o <= 8'd0;
      underrun_cnt_o <= 8'd0;
    end else begin
      hold_full      <= hold_full_n;
      hold_l         <= hold_l_n;
      hold_r         <= hold_r_n;
      dac_l_o        <= dac_l_n;
      dac_r_o        <= dac_r_n;
      overflow_cnt_o <= sat_cnt(overflow_cnt_o, overflow, clear_cnt_i);
      underrun_cnt_o <= sat_cnt(underrun_cnt_o, underrun, clear_cnt_i);
    end
  end

endmodule

// File: tb/tb_student_audio_stream_bridge.sv
// Directed bench for student_audio_stream_bridge. Expected FIFO entries are
// queued as ADC samples are driven and popped/compared as the DUT hands them
// to the filter; DAC, handshake and counter expectations come from a small
// behavioural reference kept alongside the queue.
module tb_student_audio_stream_bridge;

  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk_i;
  logic          rst_ni;
  logic [DW-1:0] adc_l_i;
  logic [DW-1:0] adc_r_i;
  logic          adc_valid_i;
  logic          bypass_i;
  logic          clear_cnt_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [DW-1:0] m_l_o;
  logic [DW-1:0] m_r_o;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] s_l_i;
  logic [DW-1:0] s_r_i;
  logic [DW-1:0] dac_l_o;
  logic [DW-1:0] dac_r_o;
  logic [7:0]    overflow_cnt_o;
  logic [7:0]    underrun_cnt_o;

  student_audio_stream_bridge #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .adc_l_i        (adc_l_i),
    .adc_r_i        (adc_r_i),
    .adc_valid_i    (adc_valid_i),
    .bypass_i       (bypass_i),
    .clear_cnt_i    (clear_cnt_i),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_l_o          (m_l_o),
    .m_r_o          (m_r_o),
    .s_valid_i      (s_valid_i),
    .s_ready_o      (s_ready_o),
    .s_l_i          (s_l_i),
    .s_r_i          (s_r_i),
    .dac_l_o        (dac_l_o),
    .dac_r_o        (dac_r_o),
    .overflow_cnt_o (overflow_cnt_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Scoreboard and reference state.
  logic [2*DW-1:0] exp_q[$];
  logic            vq_m;
  logic            hold_m;
  logic [DW-1:0]   hold_l_m, hold_r_m;
  logic [DW-1:0]   dac_l_m, dac_r_m;
  logic [7:0]      ov_m, un_m;
  logic [7:0]      saved;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    vq_m = 1'b0; hold_m = 1'b0;
    hold_l_m = '0; hold_r_m = '0;
    dac_l_m = '0; dac_r_m = '0;
    ov_m = 8'd0; un_m = 8'd0;
  endtask

  // One clock: compare outputs against the reference, update it, advance.
  task automatic cyc();
    logic tick, pop, full, hs;
    chk("m_valid", {31'd0, m_valid_o}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("m_head", {m_l_o, m_r_o}, exp_q[0]);
    chk("s_ready", {31'd0, s_ready_o}, {31'd0, ~hold_m});
    chk("dac", {dac_l_o, dac_r_o}, {dac_l_m, dac_r_m});
    chk("overflow_cnt", {24'd0, overflow_cnt_o}, {24'd0, ov_m});
    chk("underrun_cnt", {24'd0, underrun_cnt_o}, {24'd0, un_m});
    tick = adc_valid_i & ~vq_m;
    full = (exp_q.size() == DEPTH);
    pop  = (exp_q.size() != 0) & m_ready_i;
    hs   = s_valid_i & ~hold_m;
    if (pop) void'(exp_q.pop_front());
    if (tick && !bypass_i) begin
      if (!full || pop) exp_q.push_back({adc_l_i, adc_r_i});
      else if (!clear_cnt_i && ov_m != 8'd255) ov_m++;
    end
    if (tick) begin
      if (bypass_i) begin
        dac_l_m = adc_l_i; dac_r_m = adc_r_i; hold_m = 1'b0;
      end else if (hold_m) begin
        dac_l_m = hold_l_m; dac_r_m = hold_r_m; hold_m = 1'b0;
      end else if (hs) begin
        dac_l_m = s_l_i; dac_r_m = s_r_i;
      end else if (!clear_cnt_i && un_m != 8'd255) begin
        un_m++;
      end
    end else if (hs) begin
      hold_l_m = s_l_i; hold_r_m = s_r_i; hold_m = 1'b1;
    end
    if (clear_cnt_i) begin ov_m = 8'd0; un_m = 8'd0; end
    vq_m = adc_valid_i;
    @(posedge clk_i); #1;
  endtask

  // A frame: valid high for one cycle, then low for one cycle.
  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    adc_l_i = l; adc_r_i = r; adc_valid_i = 1'b1;
    cyc();
    adc_valid_i = 1'b0;
    cyc();
  endtask

  initial begin
    rst_ni = 1'b0;
    adc_l_i = '0; adc_r_i = '0; adc_valid_i = 1'b0;
    bypass_i = 1'b0; clear_cnt_i = 1'b0; m_ready_i = 1'b0;
    s_valid_i = 1'b0; s_l_i = '0; s_r_i = '0;
    model_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    chk("rst_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready_o}, 32'd1);
    chk("rst_dac", {dac_l_o, dac_r_o}, 32'd0);
    chk("rst_head", {m_l_o, m_r_o}, 32'd0);
    chk("rst_cnts", {overflow_cnt_o, underrun_cnt_o}, 32'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Level held high for 20 cycles gives exactly one FIFO entry.
    adc_l_i = 16'h1234; adc_r_i = 16'hABCD; adc_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 0) chk("lvl_m_valid_next", {31'd0, m_valid_o}, 32'd1);
    end
    chk("lvl_head", {m_l_o, m_r_o}, 32'h1234ABCD);
    chk("lvl_one_entry", exp_q.size(), 32'd1);
    chk("lvl_no_ovf", {24'd0, overflow_cnt_o}, 32'd0);
    adc_valid_i = 1'b0;
    m_ready_i = 1'b1;
    cyc();
    chk("lvl_drained", {31'd0, m_valid_o}, 32'd0);
    m_ready_i = 1'b0;

    // Six frames into a depth-4 FIFO: two dropped.
    for (int i = 1; i <= 6; i++) frame(16'(i), 16'(i + 16'h100));
    chk("ovf_two", {24'd0, overflow_cnt_o}, 32'd2);
    chk("full_head", {16'd0, m_l_o}, 32'd1);
    m_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_order", {16'd0, m_l_o}, i);
      cyc();
    end
    chk("drain_empty", {31'd0, m_valid_o}, 32'd0);
    m_ready_i = 1'b0;

    // Push into a full FIFO with a simultaneous pop is accepted.
    for (int i = 1; i <= 4; i++) frame(16'(i + 16'h20), 16'h0);
    saved = overflow_cnt_o;
    adc_l_i = 16'd7; adc_r_i = 16'h0077; adc_valid_i = 1'b1; m_ready_i = 1'b1;
    cyc();
    m_ready_i = 1'b0; adc_valid_i = 1'b0;
    cyc();
    chk("push_pop_no_ovf", {24'd0, overflow_cnt_o}, {24'd0, saved});
    chk("push_pop_occ", exp_q.size(), 32'd4);
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("seven_last", {m_l_o, m_r_o}, 32'h00070077);
      cyc();
    end

    // Filter result between ticks, then a tick with no result.
    clear_cnt_i = 1'b1; cyc(); clear_cnt_i = 1'b0;
    s_l_i = 16'h0F0F; s_r_i = 16'hF0F0; s_valid_i = 1'b1;
    cyc();
    s_valid_i = 1'b0;
    chk("hold_s_ready_low", {31'd0, s_ready_o}, 32'd0);
    cyc();
    adc_l_i = 16'h1111; adc_r_i = 16'h2222; adc_valid_i = 1'b1;
    cyc();
    chk("hold_to_dac", {dac_l_o, dac_r_o}, 32'h0F0FF0F0);
    chk("hold_s_ready_back", {31'd0, s_ready_o}, 32'd1);
    adc_valid_i = 1'b0; cyc();
    frame(16'h3333, 16'h4444);
    chk("underrun_dac_kept", {dac_l_o, dac_r_o}, 32'h0F0FF0F0);
    chk("underrun_one", {24'd0, underrun_cnt_o}, 32'd1);

    // Result handshake on the tick goes straight to the DAC.
    s_l_i = 16'h5555; s_r_i = 16'hAAAA; s_valid_i = 1'b1;
    adc_valid_i = 1'b1;
    cyc();
    s_valid_i = 1'b0; adc_valid_i = 1'b0;
    chk("direct_dac", {dac_l_o, dac_r_o}, 32'h5555AAAA);
    chk("direct_no_underrun", {24'd0, underrun_cnt_o}, 32'd1);
    for (int i = 0; i < 3; i++) cyc();
    m_ready_i = 1'b0;
    bypass_i = 1'b1;
    frame(16'h0101, 16'h0202);
    chk("bypass_dac", {16'd0, dac_l_o}, 32'h0101);
    chk("bypass_no_push", {31'd0, m_valid_o}, 32'd0);
    bypass_i = 1'b0;

    // Underrun counter saturation, then clear wins over increment.
    m_ready_i = 1'b1;
    for (int i = 0; i < 300; i++) frame(16'(i), 16'(~i));
    chk("underrun_sat", {24'd0, underrun_cnt_o}, 32'd255);
    adc_valid_i = 1'b1; clear_cnt_i = 1'b1;
    cyc();
    chk("clear_priority", {24'd0, underrun_cnt_o}, 32'd0);
    adc_valid_i = 1'b0; clear_cnt_i = 1'b0;
    cyc();

    // Asynchronous reset in the middle of traffic.
    m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) frame(16'(16'h40 + i), 16'h0);
    s_l_i = 16'h7777; s_r_i = 16'h8888; s_valid_i = 1'b1;
    cyc();
    s_valid_i = 1'b0;
    #3 rst_ni = 1'b0;
    #1;
    chk("arst_m_valid", {31'd0, m_valid_o}, 32'd0);
    chk("arst_dac", {dac_l_o, dac_r_o}, 32'd0);
    chk("arst_s_ready", {31'd0, s_ready_o}, 32'd1);
    model_reset();
    #2 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    frame(16'h9999, 16'h6666);
    chk("post_rst_head", {m_l_o, m_r_o}, 32'h99996666);
    m_ready_i = 1'b1;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/student_audio_stream_bridge.md
Name: student_audio_stream_bridge

Overview:
Sits directly downstream of the IIS codec handler. It converts the handler's per-frame stereo ADC sample (a level-type valid) into a buffered ready/valid stream for the FIR filter array. It also collects filtered samples from the filter and presents them to the handler's DAC inputs, aligned to the audio frame tick. Overflow and underrun are counted for debug.

Parameters:
DW, 16, sample width per channel
DEPTH, 4, ADC-side FIFO depth in stereo entries; power of 2, minimum 2

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset, asynchronous, active-low
adc_l_i  in  DW  left sample from IIS handler
adc_r_i  in  DW  right sample from IIS handler
adc_valid_i  in  1  IIS valid level; rises once per frame after the right channel is captured
bypass_i  in  1  1 = DAC driven directly from ADC samples, filter path ignored
clear_cnt_i  in  1  synchronous clear of both counters
m_valid_o  out  1  stream to filter: sample available
m_ready_i  in  1  stream to filter: filter accepts
m_l_o  out  DW  stream to filter: left (FIFO head)
m_r_o  out  DW  stream to filter: right (FIFO head)
s_valid_i  in  1  stream from filter: result available
s_ready_o  out  1  stream from filter: bridge accepts
s_l_i  in  DW  filtered left
s_r_i  in  DW  filtered right
dac_l_o  out  DW  left sample to IIS handler
dac_r_o  out  DW  right sample to IIS handler
overflow_cnt_o  out  8  ADC samples dropped because the FIFO was full; saturating
underrun_cnt_o  out  8  frame ticks with no filtered sample ready; saturating

Behaviour:
- Reset: all outputs 0 except s_ready_o=1. FIFO empty, hold register empty, adc_valid_q=0.
- Frame tick: tick = adc_valid_i & ~adc_valid_q, with adc_valid_q registered each cycle. Exactly one tick per 0->1 transition, so a level held high for many cycles produces one tick.
- ADC push: on tick with bypass_i=0, {adc_l_i, adc_r_i} is written the same cycle.
  - If the FIFO is full and there is no pop that cycle, the sample is dropped and overflow_cnt increments.
  - Push into a full FIFO with a simultaneous pop is accepted. Occupancy is unchanged.
- FIFO output is first-word-fall-through.
  - m_valid_o = not empty. m_l_o/m_r_o = head entry.
  - Pop on m_valid_o & m_ready_i.
  - Head and m_valid_o are registered-state-derived. A push into an empty FIFO gives m_valid_o=1 on the next cycle.
  - Pointers wrap modulo DEPTH. The occupancy counter is clog2(DEPTH)+1 bits.
  - Head must stay stable while m_valid_o=1 and m_ready_i=0.
- Return hold register: one entry.
  - s_ready_o = ~hold_full. Handshake on s_valid_i & s_ready_o loads hold, and hold_full goes to 1 next cycle.
- DAC update happens only on tick:
  - bypass_i=1: dac <= adc inputs. Hold is discarded (hold_full<=0). No push, no underrun count.
  - bypass_i=0, hold_full=1: dac <= hold, hold_full<=0.
  - bypass_i=0, hold empty, s handshake in the same cycle: dac <= s_l_i/s_r_i directly, hold stays empty, no underrun.
  - bypass_i=0, hold empty, no handshake: dac holds its previous value and underrun_cnt increments.
  - Tick with hold_full=1: s_ready_o is still 0 that cycle, so the new result is accepted next cycle.
- Counters: 8-bit, saturate at 255. clear_cnt_i has priority over increment in the same cycle.
- bypass_i may change at any time and takes effect at the next tick. FIFO contents are retained and still drain to the filter.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight samples are lost.

Test Plan:
- Reset, then adc_valid_i high for 20 cycles with L=0x1234, R=0xABCD and m_ready_i=0 -> exactly one entry; m_valid_o=1 one cycle after the tick; m_l_o=0x1234, m_r_o=0xABCD held stable; overflow_cnt_o=0.
- 6 frame ticks (L=1..6), m_ready_i=0, DEPTH=4 -> samples 1..4 stored, overflow_cnt_o=2. Then m_ready_i=1 -> pops 1,2,3,4 on consecutive cycles, then m_valid_o=0.
- FIFO full with m_ready_i=1 in the same cycle as a tick carrying L=7 -> no overflow; occupancy remains 4; 7 appears last.
- Filter returns 0x0F0F/0xF0F0 between ticks -> s_ready_o drops to 0; at the next tick dac=0x0F0F/0xF0F0 and s_ready_o=1 next cycle. Next tick with no result -> dac unchanged, underrun_cnt_o=1.
- s handshake (0x5555/0xAAAA) in the same cycle as a tick with hold empty -> dac=0x5555/0xAAAA next cycle, underrun unchanged. bypass_i=1 with tick L=0x0101 -> dac_l_o=0x0101 and the FIFO does not grow.
- 300 underrun ticks -> underrun_cnt_o saturates at 255. clear_cnt_i asserted during a tick that would increment -> 0. rst_ni pulsed mid-stream -> m_valid_o=0, dac=0, s_ready_o=1 immediately.
